seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for an N-digit common-anode 7-segment display. It shares one hex-to-segment decoder across all digits and drives one digit at a time at a programmable refresh rate, with guard blanking at every digit switch to suppress ghosting. New display values go into a double buffer and take effect only at a frame boundary, so a frame never shows a mix of old and new digits. It sits between the value-producing logic (counters, debug registers) and the board's anode/segment pins.

---
 rtl/seg_pkg.sv | 18 +
 rtl/decoder_7seg.sv | 31 +++
 rtl/seg_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Display buffers are sized for the largest supported digit count; smaller builds use the low entries.
package seg_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int SEL_W      = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [3:0] nibble_t;

  typedef struct packed {
    nibble_t [MAX_DIGITS-1:0] nibbles;
    logic    [MAX_DIGITS-1:0] dp;
    logic    [MAX_DIGITS-1:0] blank;
  } disp_buf_t;

endpackage

// File: rtl/decoder_7seg.sv
// Combinational hex-to-7-segment decoder, active-low outputs, bit 6 = g ... bit 0 = a.
module decoder_7seg
  import seg_pkg::*;
(
  input  nibble_t    hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scanner with guard blanking
// and a double buffer that only swaps at frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    upd_pending,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  disp_buf_t             act_q, act_d;
  disp_buf_t             pend_q, pend_d;
  logic                  upd_q, upd_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;

  logic                  tc;
  logic                  boundary;
  logic                  xfer;
  logic                  dark;
  logic [SEL_W-1:0]      sel;
  nibble_t               cur_nibble;
  logic [6:0]            dec_seg;

  decoder_7seg u_decoder (
    .hex (cur_nibble),
    .seg (dec_seg)
  );

  always_comb begin
    tc       = (cnt_q == CNT_LAST);
    boundary = enable && tc && (idx_q == IDX_LAST);
    // A disabled display is idle, so a pending value can be applied straight away.
    xfer     = upd_q && (boundary || !enable);

    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (tc) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    pend_d = pend_q;
    if (load) begin
      pend_d = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        pend_d.nibbles[i] = data_in[4*i +: 4];
        pend_d.dp[i]      = dp_in[i];
        pend_d.blank[i]   = blank_in[i];
      end
    end

    act_d = xfer ? pend_q : act_q;
    upd_d = load || (upd_q && !xfer);

    sel        = SEL_W'(idx_q);
    cur_nibble = act_q.nibbles[sel];
    dark       = !enable || (cnt_q < CNT_GUARD) || act_q.blank[sel];

    an_d  = dark ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    seg_d = dark ? SEG_BLANK : dec_seg;
    dp_d  = dark ? 1'b1 : ~act_q.dp[sel];
    fd_d  = boundary;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      act_q  <= '0;
      pend_q <= '0;
      upd_q  <= 1'b0;
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
      fd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      upd_q  <= upd_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      fd_q   <= fd_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign upd_pending = upd_q;
  assign frame_done  = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2.
// Cycle 0 is the cycle in which rst_n is released; outputs are sampled on the falling edge.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GD = 2;
  localparam int NV = 19;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        upd_pending;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic        ld;
    logic [15:0] data;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        fd;
    logic        upd;
  } vec_t;

  vec_t vecs [NV];

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD       (GD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .load        (load),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .upd_pending (upd_pending),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ld, input logic [15:0] data,
                               input logic [3:0] dpi, input logic [3:0] blk);
    load     = ld;
    data_in  = data;
    dp_in    = dpi;
    blank_in = blk;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                             input logic e_dp, input logic e_fd, input logic e_upd);
    checks++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp || frame_done !== e_fd || upd_pending !== e_upd) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got an=%b seg=%b dp=%b fd=%b upd=%b want an=%b seg=%b dp=%b fd=%b upd=%b",
               name, cyc, an, seg, dp, frame_done, upd_pending, e_an, e_seg, e_dp, e_fd, e_upd);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  task automatic runTo(input int c);
    while (cyc < c) stepCycle();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0000, 4'b0000, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int vi;
    int fd_count;

    // Reset release, steady scan of zeros, a mid-frame load of 1A3F and two frame boundaries.
    vecs[0]  = '{0,  1'b0, 16'h0000, 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{2,  1'b0, 16'h0000, 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3,  1'b0, 16'h0000, 4'b1110, 7'h40, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8,  1'b0, 16'h0000, 4'b1110, 7'h40, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{9,  1'b0, 16'h0000, 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{10, 1'b1, 16'h1A3F, 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{11, 1'b0, 16'h0000, 4'b1101, 7'h40, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{19, 1'b0, 16'h0000, 4'b1011, 7'h40, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{27, 1'b0, 16'h0000, 4'b0111, 7'h40, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{31, 1'b0, 16'h0000, 4'b0111, 7'h40, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{32, 1'b0, 16'h0000, 4'b0111, 7'h40, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{33, 1'b0, 16'h0000, 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{35, 1'b0, 16'h0000, 4'b1110, 7'h0E, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{43, 1'b0, 16'h0000, 4'b1101, 7'h30, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{51, 1'b0, 16'h0000, 4'b1011, 7'h08, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{59, 1'b0, 16'h0000, 4'b0111, 7'h79, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{63, 1'b0, 16'h0000, 4'b0111, 7'h79, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{64, 1'b0, 16'h0000, 4'b0111, 7'h79, 1'b1, 1'b1, 1'b0};
    vecs[18] = '{65, 1'b0, 16'h0000, 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0};

    enable = 1'b1;
    doReset();
    vi = 0;
    fd_count = 0;
    for (int c = 0; c <= 70; c++) begin
      if (c >= 1 && frame_done === 1'b1) fd_count++;
      if (vi < NV && vecs[vi].cyc == c) begin
        checkOutput($sformatf("vec%0d", vi), vecs[vi].an, vecs[vi].seg, vecs[vi].dp,
                    vecs[vi].fd, vecs[vi].upd);
        if (vecs[vi].ld) applyStimulus(1'b1, vecs[vi].data, 4'b0000, 4'b0000);
        vi++;
      end
      stepCycle();
    end
    checks++;
    if (fd_count != 2) begin
      failures++;
      $display("[TB] FAIL fd_pulse_count got=%0d want=2", fd_count);
    end

    // Two loads within one frame: only the last is shown.
    doReset();
    runTo(5);
    applyStimulus(1'b1, 16'h1111, 4'b0000, 4'b0000);
    runTo(12);
    applyStimulus(1'b1, 16'h2222, 4'b0000, 4'b0000);
    runTo(13);
    checkOutput("two_load_pend", 4'b1101, 7'h40, 1'b1, 1'b0, 1'b1);
    runTo(31);
    checkOutput("two_load_pre_bnd", 4'b0111, 7'h40, 1'b1, 1'b0, 1'b1);
    runTo(32);
    checkOutput("two_load_bnd", 4'b0111, 7'h40, 1'b1, 1'b1, 1'b0);
    runTo(35);
    checkOutput("two_load_d0", 4'b1110, 7'h24, 1'b1, 1'b0, 1'b0);
    runTo(43);
    checkOutput("two_load_d1", 4'b1101, 7'h24, 1'b1, 1'b0, 1'b0);

    // Per-digit blank and decimal point.
    doReset();
    runTo(2);
    applyStimulus(1'b1, 16'h4321, 4'b0001, 4'b0100);
    runTo(35);
    checkOutput("blank_d0_dp", 4'b1110, 7'h79, 1'b0, 1'b0, 1'b0);
    runTo(43);
    checkOutput("blank_d1", 4'b1101, 7'h24, 1'b1, 1'b0, 1'b0);
    runTo(48);
    checkOutput("blank_d1_end", 4'b1101, 7'h24, 1'b1, 1'b0, 1'b0);
    for (int c = 49; c <= 56; c++) begin
      runTo(c);
      checkOutput("blank_d2_slot", 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0);
    end
    runTo(59);
    checkOutput("blank_d3", 4'b0111, 7'h19, 1'b1, 1'b0, 1'b0);

    // Load on the boundary cycle: old pending shown now, new value one frame later.
    doReset();
    runTo(5);
    applyStimulus(1'b1, 16'h5555, 4'b0000, 4'b0000);
    runTo(31);
    checkOutput("bnd_load_pre", 4'b0111, 7'h40, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h7777, 4'b0000, 4'b0000);
    runTo(32);
    checkOutput("bnd_load_keep", 4'b0111, 7'h40, 1'b1, 1'b1, 1'b1);
    runTo(35);
    checkOutput("bnd_load_old", 4'b1110, 7'h12, 1'b1, 1'b0, 1'b1);
    runTo(63);
    checkOutput("bnd_load_old_d3", 4'b0111, 7'h12, 1'b1, 1'b0, 1'b1);
    runTo(64);
    checkOutput("bnd_load_bnd2", 4'b0111, 7'h12, 1'b1, 1'b1, 1'b0);
    runTo(67);
    checkOutput("bnd_load_new", 4'b1110, 7'h78, 1'b1, 1'b0, 1'b0);

    // Enable dropped mid-slot, then a one-cycle reset pulse mid-frame.
    doReset();
    runTo(2);
    applyStimulus(1'b1, 16'h9876, 4'b0000, 4'b0000);
    runTo(5);
    checkOutput("en_before", 4'b1110, 7'h40, 1'b1, 1'b0, 1'b1);
    enable = 1'b0;
    runTo(6);
    checkOutput("en_off_blank", 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0);
    runTo(9);
    checkOutput("en_off_hold", 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0);
    enable = 1'b1;
    runTo(11);
    checkOutput("en_on_guard", 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0);
    runTo(12);
    checkOutput("en_on_d0", 4'b1110, 7'h02, 1'b1, 1'b0, 1'b0);
    runTo(20);
    checkOutput("en_on_d1", 4'b1101, 7'h78, 1'b1, 1'b0, 1'b0);
    runTo(22);
    checkOutput("rst_before", 4'b1101, 7'h78, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    stepCycle();
    checkOutput("rst_blank", 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc = 0;
    runTo(3);
    checkOutput("rst_d0_zero", 4'b1110, 7'h40, 1'b1, 1'b0, 1'b0);
    runTo(11);
    checkOutput("rst_d1_zero", 4'b1101, 7'h40, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
